// File: rtl/pc_sequencer.sv
// Fetch/resolve sequencer that issues one nextPCop/nextPC command per instruction to the PC unit.
// Define PC_SEQ_IRQ_EN to build the interrupt overlay (mepc, handler flag, intVec, irq_ack).
module pc_sequencer #(
    parameter logic [31:0] IRQ_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC,
    output logic        fetch_req,
    input  logic        fetch_ack,
    input  logic        branch_taken,
    input  logic        jump_req,
    input  logic        mret_req,
    input  logic [31:0] target,
    input  logic        irq,
    output logic [31:0] nextPC,
    output logic [1:0]  nextPCop,
    output logic        intVec,
    output logic        irq_ack,
    output logic        misalign,
    output logic [31:0] mepc
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_INC    = 2'b01,
        OP_ASSIGN = 2'b10,
        OP_RESET  = 2'b11
    } pc_op_e;

    state_e      state_q, state_d;
    pc_op_e      cmd_op_q, cmd_op_d;
    logic [31:0] cmd_pc_q, cmd_pc_d;
    logic        mis_q, mis_d;
    logic        mret_taken;

`ifdef PC_SEQ_IRQ_EN
    logic [31:0] mepc_q, mepc_d;
    logic        hflag_q, hflag_d;
    logic        int_q, int_d;
    logic        unused_bits;

    assign mret_taken  = mret_req;
    assign unused_bits = target[0];
`else
    logic        unused_bits;

    // Interrupt support is compiled out: irq and mret are deliberately not consumed.
    assign mret_taken  = 1'b0;
    assign unused_bits = ^{irq, mret_req, target[0], IRQ_VECTOR};
`endif

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cmd_op_d = cmd_op_q;
        cmd_pc_d = cmd_pc_q;
        mis_d    = mis_q;
`ifdef PC_SEQ_IRQ_EN
        mepc_d   = mepc_q;
        hflag_d  = hflag_q;
        int_d    = int_q;
`endif
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (fetch_ack) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_UPDATE;
                mis_d   = 1'b0;
                if (mret_taken) begin
                    cmd_op_d = OP_ASSIGN;
`ifdef PC_SEQ_IRQ_EN
                    cmd_pc_d = mepc_q;
`else
                    cmd_pc_d = '0;
`endif
                end else if (jump_req || branch_taken) begin
                    cmd_op_d = OP_ASSIGN;
                    cmd_pc_d = {target[31:2], 2'b00};
                    mis_d    = target[1];
                end else begin
                    cmd_op_d = OP_INC;
                    cmd_pc_d = PC + 32'd4;
                end
`ifdef PC_SEQ_IRQ_EN
                int_d = 1'b0;
                if (mret_req) begin
                    hflag_d = 1'b0;
                end
                // An mret that clears the flag lets a pending irq re-enter at once.
                if (irq && !hflag_d) begin
                    mepc_d   = cmd_pc_d;
                    cmd_op_d = OP_ASSIGN;
                    cmd_pc_d = IRQ_VECTOR;
                    int_d    = 1'b1;
                    hflag_d  = 1'b1;
                end
`endif
            end
            ST_UPDATE: state_d = ST_FETCH;
            default:   state_d = ST_RESET;
        endcase
    end

    always_comb begin
        fetch_req = 1'b0;
        nextPCop  = OP_NOP;
        nextPC    = '0;
        intVec    = 1'b0;
        irq_ack   = 1'b0;
        misalign  = 1'b0;
        case (state_q)
            ST_RESET: nextPCop = OP_RESET;
            ST_FETCH: fetch_req = 1'b1;
            ST_UPDATE: begin
                nextPCop = cmd_op_q;
                nextPC   = cmd_pc_q;
                misalign = mis_q;
`ifdef PC_SEQ_IRQ_EN
                intVec   = int_q;
                irq_ack  = int_q;
`endif
            end
            default: ;
        endcase
    end

`ifdef PC_SEQ_IRQ_EN
    assign mepc = mepc_q;
`else
    assign mepc = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RESET;
            cmd_op_q <= OP_NOP;
            cmd_pc_q <= '0;
            mis_q    <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
            mepc_q   <= '0;
            hflag_q  <= 1'b0;
            int_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_op_q <= cmd_op_d;
            cmd_pc_q <= cmd_pc_d;
            mis_q    <= mis_d;
`ifdef PC_SEQ_IRQ_EN
            mepc_q   <= mepc_d;
            hflag_q  <= hflag_d;
            int_q    <= int_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver issues instructions and pushes expected commands,
// a monitor pops and compares whenever the DUT presents INC/ASSIGN.
module tb_pc_sequencer;

    localparam logic [31:0] IRQ_VECTOR = 32'h0000_0100;
`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef enum {P_R, P_F, P_E, P_U} phase_e;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] npc;
        logic        iv;
        logic        mis;
        logic [31:0] mepc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC;
    logic        fetch_req;
    logic        fetch_ack;
    logic        branch_taken;
    logic        jump_req;
    logic        mret_req;
    logic [31:0] target;
    logic        irq;
    logic [31:0] nextPC;
    logic [1:0]  nextPCop;
    logic        intVec;
    logic        irq_ack;
    logic        misalign;
    logic [31:0] mepc;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb_q[$];

    // Reference model state: saved return address, handler flag, expected next address.
    logic [31:0] m_mepc = '0;
    bit          m_flag = 1'b0;
    logic [31:0] m_addr = '0;

    pc_sequencer #(.IRQ_VECTOR(IRQ_VECTOR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PC           (PC),
        .fetch_req    (fetch_req),
        .fetch_ack    (fetch_ack),
        .branch_taken (branch_taken),
        .jump_req     (jump_req),
        .mret_req     (mret_req),
        .target       (target),
        .irq          (irq),
        .nextPC       (nextPC),
        .nextPCop     (nextPCop),
        .intVec       (intVec),
        .irq_ack      (irq_ack),
        .misalign     (misalign),
        .mepc         (mepc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every INC/ASSIGN the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (nextPCop == 2'b01 || nextPCop == 2'b10) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_cmd: got op %b with empty scoreboard at %0t", nextPCop, $time);
            end else begin
                e = sb_q.pop_front();
                check("cmd_op", {30'd0, nextPCop}, {30'd0, e.op});
                if (e.op == 2'b10) check("cmd_nextPC", nextPC, e.npc);
                check("cmd_intVec", {31'd0, intVec}, {31'd0, e.iv});
                check("cmd_irq_ack", {31'd0, irq_ack}, {31'd0, e.iv});
                check("cmd_misalign", {31'd0, misalign}, {31'd0, e.mis});
                check("cmd_mepc", mepc, e.mepc);
            end
        end else begin
            check("idle_pulses", {29'd0, intVec, irq_ack, misalign}, 32'd0);
        end
    end

    task automatic tick(input phase_e ph);
        @(negedge clk);
        check("fetch_req", {31'd0, fetch_req}, {31'd0, (ph == P_F)});
        if (ph == P_R) begin
            check("reset_op", {30'd0, nextPCop}, 32'd3);
            check("reset_nextPC", nextPC, 32'd0);
        end else if (ph != P_U) begin
            check("nop_op", {30'd0, nextPCop}, 32'd0);
        end
        check("mepc", mepc, m_mepc);
    endtask

    task automatic scramble_exec();
        branch_taken = 1'($urandom);
        jump_req     = 1'($urandom);
        mret_req     = 1'($urandom);
        irq          = 1'($urandom);
        target       = $urandom;
    endtask

    // Spec rules: mret > jump > branch > increment, then the interrupt overlay.
    task automatic model_exec(input bit br, input bit jp, input bit mr, input bit iq,
                              input logic [31:0] tgt);
        exp_t        e;
        logic [31:0] addr;
        bit          is_assign;
        bit          mis;
        bit          flag_eff;
        bit          take;
        mis       = 1'b0;
        is_assign = 1'b1;
        if (IRQ_EN && mr) begin
            addr = m_mepc;
        end else if (jp || br) begin
            addr = tgt & 32'hFFFF_FFFC;
            mis  = tgt[1];
        end else begin
            addr      = PC + 32'd4;
            is_assign = 1'b0;
        end
        flag_eff = (IRQ_EN && mr) ? 1'b0 : m_flag;
        take     = IRQ_EN && iq && !flag_eff;
        if (take) begin
            m_mepc    = addr;
            addr      = IRQ_VECTOR;
            is_assign = 1'b1;
        end
        m_flag = take ? 1'b1 : flag_eff;
        e.op   = is_assign ? 2'b10 : 2'b01;
        e.npc  = addr;
        e.iv   = take;
        e.mis  = mis;
        e.mepc = m_mepc;
        sb_q.push_back(e);
        m_addr = addr;
    endtask

    task automatic do_instr(input int dly, input bit br, input bit jp, input bit mr, input bit iq,
                            input logic [31:0] tgt, input bit frc, input logic [31:0] fpc);
        for (int i = 0; i <= dly; i++) begin
            tick(P_F);
            if (i == 0) begin
                if (frc) begin
                    PC     = fpc;
                    m_addr = fpc;
                end else begin
                    check("pc_at_fetch", PC, m_addr);
                end
            end
            fetch_ack = (i == dly);
            scramble_exec();
        end
        tick(P_E);
        fetch_ack    = 1'($urandom);
        branch_taken = br;
        jump_req     = jp;
        mret_req     = mr;
        irq          = iq;
        target       = tgt;
        model_exec(br, jp, mr, iq, tgt);
        tick(P_U);
        scramble_exec();
        fetch_ack = 1'($urandom);
        // PC unit: apply the issued command.
        case (nextPCop)
            2'b01:   PC = PC + 32'd4;
            2'b10:   PC = nextPC;
            2'b11:   PC = '0;
            default: ;
        endcase
    endtask

    task automatic reset_mid_fetch();
        tick(P_F);
        fetch_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_op", {30'd0, nextPCop}, 32'd3);
        check("async_reset_mepc", mepc, 32'd0);
        check("async_reset_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("async_reset_nextPC", nextPC, 32'd0);
        m_mepc = '0;
        m_flag = 1'b0;
        m_addr = '0;
        PC     = '0;
        tick(P_R);
        tick(P_R);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        PC           = '0;
        fetch_ack    = 1'b0;
        branch_taken = 1'b0;
        jump_req     = 1'b0;
        mret_req     = 1'b0;
        irq          = 1'b0;
        target       = '0;
        repeat (3) tick(P_R);
        rst_n = 1'b1;

        repeat (3) do_instr(0, 0, 0, 0, 0, 32'd0, 1'b0, 32'd0);
        do_instr(2, 0, 0, 0, 0, 32'd0, 1'b0, 32'd0);
        do_instr(0, 1, 0, 0, 0, 32'h0000_1002, 1'b1, 32'h0000_0040);
        do_instr(0, 0, 0, 0, 1, 32'd0, 1'b1, 32'h0000_0040);
        do_instr(0, 0, 0, 0, 1, 32'd0, 1'b0, 32'd0);
        do_instr(1, 0, 0, 1, 0, 32'd0, 1'b0, 32'd0);
        do_instr(0, 0, 0, 0, 1, 32'd0, 1'b1, 32'h0000_0200);
        reset_mid_fetch();
        do_instr(0, 0, 0, 0, 0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        do_instr(0, 0, 0, 0, 0, 32'd0, 1'b0, 32'd0);

        for (int n = 0; n < 250; n++) begin
            bit frc;
            frc = ($urandom_range(0, 9) == 0);
            do_instr($urandom_range(0, 2),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 3) == 0),
                     $urandom,
                     frc,
                     ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC));
        end

        tick(P_F);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
